// File: rtl/mul_seq_arbiter.sv
// Purpose : round-robin arbiter feeding a 4-beat constant multiplier (x1, x3, x7, x8).
// Latency : grant/handshake at edge T, first beat registered at T, visible before T+1; 5 cycles minimum per op.
// Backpressure: out_ready low freezes every out_* register indefinitely; req_ready is zero while RUN.
//
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   req_valid     per-requester operand pending
//   req_data      8-bit operand per requester, lane i on bits [8i+7:8i]
//   req_ready     one-hot grant (IDLE only)
//   out_valid     result beat present
//   out_ready     consumer accept
//   out_data      operand * K[idx], 11 bits
//   out_id        owner of the current beat
//   out_idx       beat index 0..3
//   out_last      final beat
//   busy          operation in progress
module mul_seq_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [10:0]       out_data,
    output logic [IDW-1:0]    out_id,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [1:0]     step;
    logic [7:0]     operand;
    logic [IDW-1:0] last_id;

    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;
    logic           any_vld;
    logic [7:0]     win_data;

    // Constant multiply by shift-and-add; 11 bits holds 255*8 without wrap.
    function automatic logic [10:0] scale(input logic [7:0] d, input logic [1:0] s);
        logic [10:0] x;
        x = {3'b000, d};
        case (s)
            2'd0:    return x;
            2'd1:    return (x << 1) + x;
            2'd2:    return (x << 2) + (x << 1) + x;
            default: return x << 3;
        endcase
    endfunction

    // Search from last_id+1 upward with wrap. Iterating from the farthest
    // candidate down lets the nearest set bit overwrite, so it wins.
    always_comb begin
        win_id = '0;
        cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = last_id + IDW'(k);
            if (req_valid[cand]) begin
                win_id = cand;
            end
        end
    end

    assign any_vld  = |req_valid;
    assign win_data = req_data[{win_id, 3'b000} +: 8];

    // Gated by rst so the grant is quiet while reset is held.
    assign req_ready = (rst && state == IDLE && any_vld) ? (NREQ'(1) << win_id) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            operand   <= 8'd0;
            last_id   <= IDW'(NREQ - 1);
            out_valid <= 1'b0;
            out_data  <= 11'd0;
            out_id    <= '0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Any set req_valid implies a grant, hence a handshake.
                    if (any_vld) begin
                        operand   <= win_data;
                        out_id    <= win_id;
                        step      <= 2'd0;
                        state     <= RUN;
                        out_valid <= 1'b1;
                        out_data  <= scale(win_data, 2'd0);
                        out_idx   <= 2'd0;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (step != 2'd3) begin
                            step     <= step + 2'd1;
                            out_data <= scale(operand, step + 2'd1);
                            out_idx  <= step + 2'd1;
                            out_last <= (step == 2'd2);
                        end else begin
                            last_id   <= out_id;
                            state     <= IDLE;
                            step      <= 2'd0;
                            out_valid <= 1'b0;
                            out_data  <= 11'd0;
                            out_idx   <= 2'd0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Purpose : directed self-checking bench for mul_seq_arbiter (NREQ=4).
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpressure: out_ready driven directly by the stimulus.
module tb_mul_seq_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic [1:0]  out_id;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int kmul [4] = '{1, 3, 7, 8};

    mul_seq_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_id   (out_id),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_beat(input int id, input int d, input int s);
        check("beat_vld",  32'(out_valid), 32'd1);
        check("beat_data", 32'(out_data),  32'(d * kmul[s]));
        check("beat_idx",  32'(out_idx),   32'(s));
        check("beat_id",   32'(out_id),    32'(id));
        check("beat_last", 32'(out_last),  32'(s == 3));
        check("beat_busy", 32'(busy),      32'd1);
        check("beat_rdy",  32'(req_ready), 32'd0);
    endtask

    task automatic check_idle();
        check("idle_busy", 32'(busy),      32'd0);
        check("idle_vld",  32'(out_valid), 32'd0);
    endtask

    // Called on a falling edge in IDLE with requests set up; runs a full op
    // at out_ready=1. With clr, requests drop and data is scrambled right
    // after the handshake, so the result must come from the latched value.
    task automatic do_op(input int id, input int d, input bit clr);
        #1;
        check("grant", 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        if (clr) begin
            req_valid = 4'b0000;
            req_data  = ~req_data;
        end
        for (int s = 0; s < 4; s++) begin
            check_beat(id, d, s);
            @(negedge clk);
        end
        check_idle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state, with requests pending.
        check("rst_rdy",  32'(req_ready), 32'd0);
        check("rst_vld",  32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data),  32'd0);
        check("rst_idx",  32'(out_idx),   32'd0);
        check("rst_id",   32'(out_id),    32'd0);
        check("rst_last", 32'(out_last),  32'd0);
        check("rst_busy", 32'(busy),      32'd0);

        // Single op, d0=25 -> 25, 75, 175, 200.
        rst       = 1'b1;
        req_valid = 4'b0001;
        req_data  = {8'd0, 8'd0, 8'd0, 8'd25};
        do_op(0, 25, 1);

        // Max operand -> 255, 765, 1785, 2040.
        req_valid = 4'b0001;
        req_data  = {8'd0, 8'd0, 8'd0, 8'd255};
        do_op(0, 255, 1);

        // Requester dropping before the edge is never granted.
        req_valid = 4'b0010;
        #1;
        check("drop_grant", 32'(req_ready), 32'b0010);
        req_valid = 4'b0000;
        @(negedge clk);
        check("drop_busy", 32'(busy), 32'd0);

        // Fairness from reset with all requests held: 0,1,2,3,0.
        do_reset();
        req_valid = 4'b1111;
        req_data  = {8'd13, 8'd12, 8'd11, 8'd10};
        do_op(0, 10, 0);
        do_op(1, 11, 0);
        do_op(2, 12, 0);
        do_op(3, 13, 0);
        do_op(0, 10, 0);
        req_valid = 4'b0000;
        @(negedge clk);

        // Backpressure on beat idx1, d=10.
        req_valid = 4'b0001;
        req_data  = {8'd0, 8'd0, 8'd0, 8'd10};
        #1;
        check("bp_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        check_beat(0, 10, 0);
        @(negedge clk);
        check_beat(0, 10, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_data", 32'(out_data), 32'd30);
            check("bp_hold_idx",  32'(out_idx),  32'd1);
            check("bp_hold_vld",  32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_beat(0, 10, 2);
        @(negedge clk);
        check_beat(0, 10, 3);
        @(negedge clk);
        check_idle();

        // Reset during beat idx2 clears outputs immediately.
        req_valid = 4'b0001;
        req_data  = {8'd0, 8'd0, 8'd0, 8'd20};
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check_beat(0, 20, 2);
        rst = 1'b0;
        #1;
        check("mr_vld",  32'(out_valid), 32'd0);
        check("mr_data", 32'(out_data),  32'd0);
        check("mr_idx",  32'(out_idx),   32'd0);
        check("mr_last", 32'(out_last),  32'd0);
        check("mr_busy", 32'(busy),      32'd0);
        check("mr_rdy",  32'(req_ready), 32'd0);
        req_valid = 4'b0110;
        req_data  = {8'd0, 8'd22, 8'd21, 8'd0};
        @(negedge clk);
        check("mr_still", 32'(out_valid), 32'd0);
        rst = 1'b1;
        do_op(1, 21, 1);

        // Late arrival: req2 shows up during req0's run, req1 absent.
        // last_id=1, so req0 alone is granted first.
        req_valid = 4'b0001;
        req_data  = {8'd0, 8'd0, 8'd0, 8'd5};
        #1;
        check("late_grant0", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = {8'd0, 8'd50, 8'd0, 8'd0};
        for (int s = 0; s < 4; s++) begin
            check_beat(0, 5, s);
            if (s == 2) req_data = {8'd0, 8'd66, 8'd0, 8'd0};
            @(negedge clk);
        end
        do_op(2, 66, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq_arbiter.md
MUL_SEQ_ARBITER -- requirements
Module: mul_seq_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters; power of two, legal range 2..8.
REQ-002 Parameter: IDW, default 2, requester-ID width; SHALL equal log2(NREQ).
REQ-003 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  input  NREQ  bit i set = requester i has an operand pending.
REQ-006 Port: req_data  input  8*NREQ  operand of requester i on bits [8i+7:8i], unsigned.
REQ-007 Port: req_ready  output  NREQ  one-hot grant; operand i accepted on a cycle with req_valid[i] and req_ready[i] both high.
REQ-008 Port: out_valid  output  1  result beat present.
REQ-009 Port: out_ready  input  1  consumer accepts the beat on a cycle with out_valid and out_ready both high.
REQ-010 Port: out_data  output  11  product of the latched operand and the current constant, unsigned.
REQ-011 Port: out_id  output  IDW  requester that owns the current beat.
REQ-012 Port: out_idx  output  2  beat index, 0..3.
REQ-013 Port: out_last  output  1  high when out_idx equals 3.
REQ-014 Port: busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states are IDLE and RUN; no other states exist.
REQ-016 IDLE: req_ready SHALL be one-hot on the round-robin winner among set req_valid bits.
REQ-017 IDLE: req_ready SHALL be all-zero when req_valid is zero.
REQ-018 In RUN, req_ready SHALL be all-zero.
REQ-019 Round-robin search SHALL start at (last_id+1) mod NREQ and proceed upward with wrap-around.
REQ-020 On an IDLE handshake: latch the operand and winner ID, set step to 0, move to RUN.
REQ-021 RUN: out_valid SHALL be 1.
REQ-022 RUN: out_data SHALL equal operand*K[step], with K = {1, 3, 7, 8} for step 0..3.
REQ-023 RUN: out_idx SHALL equal step and out_id SHALL equal the latched ID.
REQ-024 Products SHALL be formed by shift-and-add only, no multiplier operator: x1 = d; x3 = (d<<1)+d; x7 = (d<<2)+(d<<1)+d; x8 = d<<3.
REQ-025 Arithmetic SHALL be at 11 bits; maximum 255*8 = 2040, so no overflow or truncation occurs.
REQ-026 All outputs SHALL be driven from registers, except req_ready, which decodes state and req_valid.
REQ-027 No combinational path SHALL exist from out_ready to any output.
REQ-028 RUN beat accepted with step < 3: step increments.
REQ-029 RUN beat accepted with step = 3: last_id updates to the latched ID and the FSM returns to IDLE.
REQ-030 With out_ready low, all out_* signals SHALL hold their values unchanged; stall length is unbounded.
REQ-031 Latency: handshake at edge T; first beat visible after edge T, sampled at edge T+1.
REQ-032 Minimum occupancy is 5 cycles per operation: 1 grant cycle plus 4 beats.
REQ-033 A requester dropping req_valid before its handshake SHALL NOT be granted.
REQ-034 req_data and req_valid changes during RUN SHALL NOT affect the latched operand.
REQ-035 Requesters arriving during RUN wait; arbitration is evaluated afresh in IDLE.
REQ-036 Under continuous requests from all NREQ requesters, every requester SHALL be granted once per NREQ operations (no starvation).

Reset
REQ-037 When rst is low: state = IDLE, step = 0, operand = 0, out_id = 0.
REQ-038 When rst is low: last_id = NREQ-1, so requester 0 has first priority.
REQ-039 When rst is low: out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0, req_ready = 0.
REQ-040 Reset asserted mid-RUN SHALL abort the operation immediately (asynchronously); no partial beat follows deassertion.
REQ-041 After rst deasserts, the first grant can occur on the next clk edge.

Verification
REQ-042 Single op: req_valid=0001, d0=8'd25, out_ready=1 -> beats 25, 75, 175, 200, id 0, idx 0..3, out_last on beat 4, then busy=0.
REQ-043 Max operand: d=8'd255 -> beats 255, 765, 1785, 2040 with no wrap.
REQ-044 Fairness: req_valid=1111 held, NREQ=4 -> grant order 0,1,2,3,0.
REQ-045 Backpressure: out_ready low 3 cycles during beat idx1 (d=10) -> out_data stays 30 and out_idx stays 1; resumes with 70 then 80.
REQ-046 Mid-op reset: rst low during beat idx2 -> all outputs 0 immediately; after release, req_valid=0110 -> grant to requester 1 first.
REQ-047 Late arrival: req2 asserts during RUN of req0 and req1 is absent -> req2 granted in the next IDLE cycle, while its d changes during the wait; result uses the value at handshake.
